// File: rtl/mult8b_rev_seq_if.sv
// Request/response bundle between a client and the reversible-multiplier sequencer.
// The client pushes forward computes, requests uncomputes and sees results and LIFO occupancy.
interface mult8b_rev_seq_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic          fwd_valid;
    logic          fwd_ready;
    logic [7:0]    fwd_a;
    logic [7:0]    fwd_b;
    logic          res_valid;
    logic [15:0]   res_p;
    logic          bwd_valid;
    logic          bwd_ready;
    logic          rec_valid;
    logic [7:0]    rec_a;
    logic [7:0]    rec_b;
    logic [CW-1:0] stack_cnt;

    modport master (
        output fwd_valid, fwd_a, fwd_b, bwd_valid,
        input  fwd_ready, res_valid, res_p, bwd_ready, rec_valid, rec_a, rec_b, stack_cnt
    );

    modport slave (
        input  fwd_valid, fwd_a, fwd_b, bwd_valid,
        output fwd_ready, res_valid, res_p, bwd_ready, rec_valid, rec_a, rec_b, stack_cnt
    );
endinterface

// File: rtl/mult8b_rev_seq.sv
// Sequencer for the bidirectional reversible 8x8 multiplier: owns the macro dir pin, inserts
// turnaround/settle time and keeps forward results {p, garbage} on a LIFO for later uncompute.
module mult8b_rev_seq #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned TURN_CYC   = 1,
    parameter int unsigned DEPTH      = 4
) (
    input  logic               clk,
    input  logic               rst,
    mult8b_rev_seq_if.slave    host,
    output logic               m_dir,
    output logic [7:0]         m_f_a,
    output logic [7:0]         m_f_b,
    input  logic [15:0]        m_f_p,
    input  logic [62:0]        m_f_garb,
    output logic [15:0]        m_r_p,
    output logic [62:0]        m_r_garb,
    input  logic [7:0]         m_r_a,
    input  logic [7:0]         m_r_b
);
    localparam int unsigned CW      = $clog2(DEPTH + 1);
    localparam int unsigned AW      = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int unsigned EW      = 79;
    localparam int unsigned CTMAX   = (SETTLE_CYC > TURN_CYC) ? SETTLE_CYC : TURN_CYC;
    localparam int unsigned CTW     = (CTMAX <= 2) ? 1 : $clog2(CTMAX);
    localparam int unsigned SET_LD  = SETTLE_CYC - 1;
    localparam int unsigned TURN_LD = (TURN_CYC == 0) ? 0 : TURN_CYC - 1;

    typedef enum logic [1:0] {IDLE, TURN, FSET, BSET} state_t;

    state_t         state_q, state_d;
    logic [CTW-1:0] ctr_q, ctr_d;
    logic [CW-1:0]  cnt_d;
    logic           dir_d;
    logic [7:0]     fa_d, fb_d;
    logic [15:0]    rp_d;
    logic [62:0]    rgarb_d;
    logic           resv_d, recv_d;
    logic [15:0]    resp_d;
    logic [7:0]     reca_d, recb_d;
    logic           fready_d, bready_d;
    logic           push;
    logic [EW-1:0]  mem [DEPTH];
    logic [EW-1:0]  top_c;

    assign top_c = mem[AW'(host.stack_cnt - CW'(1))];

    // Next-state and next-output logic; the TURN target is implied by the already-flipped dir.
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        cnt_d   = host.stack_cnt;
        dir_d   = m_dir;
        fa_d    = m_f_a;
        fb_d    = m_f_b;
        rp_d    = m_r_p;
        rgarb_d = m_r_garb;
        resv_d  = 1'b0;
        resp_d  = host.res_p;
        recv_d  = 1'b0;
        reca_d  = host.rec_a;
        recb_d  = host.rec_b;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (host.bwd_valid && host.bwd_ready) begin
                    {rp_d, rgarb_d} = top_c;
                    cnt_d = host.stack_cnt - CW'(1);
                    if (m_dir || TURN_CYC == 0) begin
                        state_d = BSET;
                        ctr_d   = CTW'(SET_LD);
                    end else begin
                        state_d = TURN;
                        ctr_d   = CTW'(TURN_LD);
                    end
                    dir_d = 1'b1;
                end else if (host.fwd_valid && host.fwd_ready) begin
                    fa_d = host.fwd_a;
                    fb_d = host.fwd_b;
                    if (!m_dir || TURN_CYC == 0) begin
                        state_d = FSET;
                        ctr_d   = CTW'(SET_LD);
                    end else begin
                        state_d = TURN;
                        ctr_d   = CTW'(TURN_LD);
                    end
                    dir_d = 1'b0;
                end
            end
            TURN: begin
                if (ctr_q == '0) begin
                    state_d = m_dir ? BSET : FSET;
                    ctr_d   = CTW'(SET_LD);
                end else begin
                    ctr_d = ctr_q - CTW'(1);
                end
            end
            FSET: begin
                if (ctr_q == '0) begin
                    push    = 1'b1;
                    cnt_d   = host.stack_cnt + CW'(1);
                    resp_d  = m_f_p;
                    resv_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    ctr_d = ctr_q - CTW'(1);
                end
            end
            BSET: begin
                if (ctr_q == '0) begin
                    reca_d  = m_r_a;
                    recb_d  = m_r_b;
                    recv_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    ctr_d = ctr_q - CTW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        fready_d = (state_d == IDLE) && (cnt_d != CW'(DEPTH));
        bready_d = (state_d == IDLE) && (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            ctr_q          <= '0;
            host.stack_cnt <= '0;
            m_dir          <= 1'b0;
            m_f_a          <= '0;
            m_f_b          <= '0;
            m_r_p          <= '0;
            m_r_garb       <= '0;
            host.res_valid <= 1'b0;
            host.res_p     <= '0;
            host.rec_valid <= 1'b0;
            host.rec_a     <= '0;
            host.rec_b     <= '0;
            host.fwd_ready <= 1'b1;
            host.bwd_ready <= 1'b0;
        end else begin
            state_q        <= state_d;
            ctr_q          <= ctr_d;
            host.stack_cnt <= cnt_d;
            m_dir          <= dir_d;
            m_f_a          <= fa_d;
            m_f_b          <= fb_d;
            m_r_p          <= rp_d;
            m_r_garb       <= rgarb_d;
            host.res_valid <= resv_d;
            host.res_p     <= resp_d;
            host.rec_valid <= recv_d;
            host.rec_a     <= reca_d;
            host.rec_b     <= recb_d;
            host.fwd_ready <= fready_d;
            host.bwd_ready <= bready_d;
        end
    end

    // LIFO storage; contents are don't-care above the occupancy pointer, so no reset.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[AW'(host.stack_cnt)] <= {m_f_p, m_f_garb};
        end
    end
endmodule

// File: tb/tb_mult8b_rev_seq.sv
// Directed bench for mult8b_rev_seq with a behavioral reversible-multiplier macro that
// returns X whenever its inputs or direction changed too recently.
module tb_mult8b_rev_seq;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned TURN   = 1;
    localparam int unsigned DEPTH  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult8b_rev_seq_if #(.DEPTH(DEPTH)) ifc ();

    logic        m_dir;
    logic [7:0]  m_f_a, m_f_b, m_r_a, m_r_b;
    logic [15:0] m_f_p, m_r_p;
    logic [62:0] m_f_garb, m_r_garb;

    mult8b_rev_seq #(.SETTLE_CYC(SETTLE), .TURN_CYC(TURN), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .host     (ifc),
        .m_dir    (m_dir),
        .m_f_a    (m_f_a),
        .m_f_b    (m_f_b),
        .m_f_p    (m_f_p),
        .m_f_garb (m_f_garb),
        .m_r_p    (m_r_p),
        .m_r_garb (m_r_garb),
        .m_r_a    (m_r_a),
        .m_r_b    (m_r_b)
    );

    // Macro model: garbage = {a^b low 7 bits, 40 zeros, a^3C, b^C3}; backward checks consistency.
    logic [95:0] snap, cur;
    int          stab = 0;
    logic        settled;
    logic [7:0]  ra, rb;
    logic        r_ok;
    assign cur     = {m_dir, m_f_a, m_f_b, m_r_p, m_r_garb};
    assign settled = (cur === snap) && (stab >= int'(SETTLE) - 1);
    assign ra      = m_r_garb[15:8] ^ 8'h3C;
    assign rb      = m_r_garb[7:0] ^ 8'hC3;
    assign r_ok    = (m_r_p == 16'(ra) * 16'(rb)) && (m_r_garb[62:56] == (ra[6:0] ^ rb[6:0]))
                     && (m_r_garb[55:16] == 40'h0);
    always @(negedge clk) begin
        if (cur !== snap) begin
            snap <= cur;
            stab <= 0;
        end else if (stab < 1000) begin
            stab <= stab + 1;
        end
    end
    always_comb begin
        m_f_p    = 'x;
        m_f_garb = 'x;
        m_r_a    = 'x;
        m_r_b    = 'x;
        if (settled && m_dir === 1'b0) begin
            m_f_p    = 16'(m_f_a) * 16'(m_f_b);
            m_f_garb = {7'(m_f_a[6:0] ^ m_f_b[6:0]), 40'h0, m_f_a ^ 8'h3C, m_f_b ^ 8'hC3};
        end
        if (settled && m_dir === 1'b1 && r_ok) begin
            m_r_a = ra;
            m_r_b = rb;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          res_cyc_q[$];
    logic [15:0] res_p_q[$];
    int          rec_cyc_q[$];
    logic [15:0] rec_q[$];
    always @(negedge clk) begin
        if (ifc.res_valid === 1'b1) begin
            res_cyc_q.push_back(cyc);
            res_p_q.push_back(ifc.res_p);
        end
        if (ifc.rec_valid === 1'b1) begin
            rec_cyc_q.push_back(cyc);
            rec_q.push_back({ifc.rec_a, ifc.rec_b});
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic fwd_req(input logic [7:0] a, input logic [7:0] b, output int hs);
        int n = 0;
        ifc.fwd_a = a;
        ifc.fwd_b = b;
        ifc.fwd_valid = 1'b1;
        while (ifc.fwd_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n >= 200) begin failures++; $display("FAIL fwd_ready_wait got=timeout exp=ready"); end
        @(posedge clk); #1;
        hs = cyc;
        ifc.fwd_valid = 1'b0;
    endtask

    task automatic bwd_req(output int hs);
        int n = 0;
        ifc.bwd_valid = 1'b1;
        while (ifc.bwd_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n >= 200) begin failures++; $display("FAIL bwd_ready_wait got=timeout exp=ready"); end
        @(posedge clk); #1;
        hs = cyc;
        ifc.bwd_valid = 1'b0;
    endtask

    task automatic drive_pair(input logic [7:0] a, input logic [7:0] b, output int hs_f, output int hs_b);
        logic tb_hs, tf_hs;
        int n = 0;
        hs_f = -1;
        hs_b = -1;
        ifc.fwd_a = a;
        ifc.fwd_b = b;
        ifc.fwd_valid = 1'b1;
        ifc.bwd_valid = 1'b1;
        while ((ifc.fwd_valid || ifc.bwd_valid) && n < 200) begin
            tb_hs = ifc.bwd_valid && (ifc.bwd_ready === 1'b1);
            tf_hs = ifc.fwd_valid && (ifc.fwd_ready === 1'b1) && !tb_hs;
            @(posedge clk); #1; n++;
            if (tb_hs) begin hs_b = cyc; ifc.bwd_valid = 1'b0; end
            if (tf_hs) begin hs_f = cyc; ifc.fwd_valid = 1'b0; end
        end
        ifc.fwd_valid = 1'b0;
        ifc.bwd_valid = 1'b0;
        checks++;
        if (n >= 200) begin failures++; $display("FAIL pair_handshake got=timeout exp=both_taken"); end
    endtask

    task automatic wait_res(output int c, output logic [15:0] p);
        int n = 0;
        while (res_cyc_q.size() == 0 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (res_cyc_q.size() == 0) begin
            failures++;
            $display("FAIL res_valid_wait got=timeout exp=pulse");
            c = -100;
            p = 'x;
        end else begin
            c = res_cyc_q.pop_front();
            p = res_p_q.pop_front();
        end
    endtask

    task automatic wait_rec(output int c, output logic [15:0] ab);
        int n = 0;
        while (rec_cyc_q.size() == 0 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (rec_cyc_q.size() == 0) begin
            failures++;
            $display("FAIL rec_valid_wait got=timeout exp=pulse");
            c = -100;
            ab = 'x;
        end else begin
            c = rec_cyc_q.pop_front();
            ab = rec_q.pop_front();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ifc.stack_cnt !== 3'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", ifc.stack_cnt); end
        checks++; if (m_dir !== 1'b0) begin failures++; $display("FAIL rst_dir got=%b exp=0", m_dir); end
        checks++; if ({ifc.fwd_ready, ifc.bwd_ready} !== 2'b10) begin failures++; $display("FAIL rst_ready got=%b exp=10", {ifc.fwd_ready, ifc.bwd_ready}); end
        checks++; if ({ifc.res_valid, ifc.rec_valid} !== 2'b00) begin failures++; $display("FAIL rst_valid got=%b exp=00", {ifc.res_valid, ifc.rec_valid}); end
        checks++; if ({m_f_a, m_f_b, m_r_p, m_r_garb} !== 95'd0) begin failures++; $display("FAIL rst_macro_regs got=%h exp=0", {m_f_a, m_f_b, m_r_p, m_r_garb}); end
        checks++; if ({ifc.res_p, ifc.rec_a, ifc.rec_b} !== 32'd0) begin failures++; $display("FAIL rst_results got=%h exp=0", {ifc.res_p, ifc.rec_a, ifc.rec_b}); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fwd_basic();
        int hs, c;
        logic [15:0] p;
        fwd_req(8'd3, 8'd5, hs);
        checks++; if (m_dir !== 1'b0) begin failures++; $display("FAIL fwd1_dir_hs got=%b exp=0", m_dir); end
        wait_res(c, p);
        checks++; if (c - hs != 2) begin failures++; $display("FAIL fwd1_latency got=%0d exp=2", c - hs); end
        checks++; if (p !== 16'd15) begin failures++; $display("FAIL fwd1_p got=%h exp=000f", p); end
        checks++; if (m_dir !== 1'b0) begin failures++; $display("FAIL fwd1_dir got=%b exp=0", m_dir); end
        checks++; if (ifc.stack_cnt !== 3'd1) begin failures++; $display("FAIL fwd1_cnt got=%0d exp=1", ifc.stack_cnt); end
    endtask

    task automatic test_bwd_basic();
        int hs, c;
        logic [15:0] ab;
        bwd_req(hs);
        checks++; if (m_dir !== 1'b1) begin failures++; $display("FAIL bwd1_dir_hs got=%b exp=1", m_dir); end
        wait_rec(c, ab);
        checks++; if (c - hs != 3) begin failures++; $display("FAIL bwd1_latency got=%0d exp=3", c - hs); end
        checks++; if (ab !== 16'h0305) begin failures++; $display("FAIL bwd1_ab got=%h exp=0305", ab); end
        checks++; if (ifc.stack_cnt !== 3'd0 || ifc.bwd_ready !== 1'b0) begin
            failures++; $display("FAIL bwd1_empty got=cnt%0d/rdy%b exp=cnt0/rdy0", ifc.stack_cnt, ifc.bwd_ready);
        end
    endtask

    task automatic test_lifo_order();
        int hs, c;
        logic [15:0] v;
        fwd_req(8'h12, 8'h34, hs);
        wait_res(c, v);
        checks++; if (c - hs != 3 || v !== 16'h03A8) begin failures++; $display("FAIL lifo_res1 got=lat%0d/%h exp=lat3/03a8", c - hs, v); end
        fwd_req(8'hFF, 8'hFF, hs);
        wait_res(c, v);
        checks++; if (c - hs != 2 || v !== 16'hFE01) begin failures++; $display("FAIL lifo_res2 got=lat%0d/%h exp=lat2/fe01", c - hs, v); end
        bwd_req(hs);
        wait_rec(c, v);
        checks++; if (c - hs != 3 || v !== 16'hFFFF) begin failures++; $display("FAIL lifo_rec1 got=lat%0d/%h exp=lat3/ffff", c - hs, v); end
        bwd_req(hs);
        wait_rec(c, v);
        checks++; if (c - hs != 2 || v !== 16'h1234) begin failures++; $display("FAIL lifo_rec2 got=lat%0d/%h exp=lat2/1234", c - hs, v); end
        checks++; if (ifc.stack_cnt !== 3'd0) begin failures++; $display("FAIL lifo_cnt got=%0d exp=0", ifc.stack_cnt); end
    endtask

    task automatic test_full();
        int hs, c, hs_f, hs_b, rc;
        logic [15:0] v;
        logic [15:0] exp_p [4] = '{16'd2, 16'd12, 16'd30, 16'd56};
        logic [15:0] exp_r [3] = '{16'h090A, 16'h0506, 16'h0304};
        for (int i = 0; i < 4; i++) begin
            fwd_req(8'(2 * i + 1), 8'(2 * i + 2), hs);
            wait_res(c, v);
            checks++; if (v !== exp_p[i]) begin failures++; $display("FAIL full_fill_p%0d got=%h exp=%h", i, v, exp_p[i]); end
        end
        checks++; if (ifc.stack_cnt !== 3'd4 || ifc.fwd_ready !== 1'b0) begin
            failures++; $display("FAIL full_state got=cnt%0d/rdy%b exp=cnt4/rdy0", ifc.stack_cnt, ifc.fwd_ready);
        end
        ifc.fwd_a = 8'd9;
        ifc.fwd_b = 8'd10;
        ifc.fwd_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (res_cyc_q.size() != 0 || ifc.stack_cnt !== 3'd4) begin
            failures++; $display("FAIL full_stall got=pulses%0d/cnt%0d exp=pulses0/cnt4", res_cyc_q.size(), ifc.stack_cnt);
        end
        drive_pair(8'd9, 8'd10, hs_f, hs_b);
        wait_rec(rc, v);
        checks++; if (rc - hs_b != 3 || v !== 16'h0708) begin failures++; $display("FAIL full_pop got=lat%0d/%h exp=lat3/0708", rc - hs_b, v); end
        checks++; if (hs_f != rc + 1) begin failures++; $display("FAIL full_fwd_after_pop got=%0d exp=%0d", hs_f, rc + 1); end
        wait_res(c, v);
        checks++; if (c - hs_f != 3 || v !== 16'd90) begin failures++; $display("FAIL full_5th got=lat%0d/%h exp=lat3/005a", c - hs_f, v); end
        checks++; if (ifc.stack_cnt !== 3'd4) begin failures++; $display("FAIL full_cnt_after got=%0d exp=4", ifc.stack_cnt); end
        for (int i = 0; i < 3; i++) begin
            bwd_req(hs);
            wait_rec(c, v);
            checks++; if (v !== exp_r[i]) begin failures++; $display("FAIL full_drain%0d got=%h exp=%h", i, v, exp_r[i]); end
        end
    endtask

    task automatic test_priority();
        int hs_f, hs_b, rc, c;
        logic [15:0] v;
        checks++; if (ifc.stack_cnt !== 3'd1 || m_dir !== 1'b1) begin
            failures++; $display("FAIL prio_setup got=cnt%0d/dir%b exp=cnt1/dir1", ifc.stack_cnt, m_dir);
        end
        drive_pair(8'h10, 8'h11, hs_f, hs_b);
        wait_rec(rc, v);
        checks++; if (rc - hs_b != 2 || v !== 16'h0102) begin failures++; $display("FAIL prio_bwd got=lat%0d/%h exp=lat2/0102", rc - hs_b, v); end
        checks++; if (hs_f != rc + 1) begin failures++; $display("FAIL prio_order got=%0d exp=%0d", hs_f, rc + 1); end
        wait_res(c, v);
        checks++; if (c - hs_f != 3 || v !== 16'h0110) begin failures++; $display("FAIL prio_fwd got=lat%0d/%h exp=lat3/0110", c - hs_f, v); end
        checks++; if (ifc.stack_cnt !== 3'd1 || m_dir !== 1'b0) begin
            failures++; $display("FAIL prio_end got=cnt%0d/dir%b exp=cnt1/dir0", ifc.stack_cnt, m_dir);
        end
    endtask

    task automatic test_reset_abort();
        int hs, c;
        logic [15:0] v;
        fwd_req(8'd7, 8'd9, hs);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (ifc.stack_cnt !== 3'd0 || m_dir !== 1'b0 || ifc.bwd_ready !== 1'b0) begin
            failures++; $display("FAIL abort_fset got=cnt%0d/dir%b/brdy%b exp=cnt0/dir0/brdy0", ifc.stack_cnt, m_dir, ifc.bwd_ready);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (res_cyc_q.size() != 0) begin failures++; $display("FAIL abort_no_res got=%0d exp=0", res_cyc_q.size()); end
        fwd_req(8'd7, 8'd9, hs);
        wait_res(c, v);
        checks++; if (c - hs != 2 || v !== 16'd63) begin failures++; $display("FAIL abort_refwd got=lat%0d/%h exp=lat2/003f", c - hs, v); end
        bwd_req(hs);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (m_dir !== 1'b0 || ifc.stack_cnt !== 3'd0) begin
            failures++; $display("FAIL abort_bwd got=dir%b/cnt%0d exp=dir0/cnt0", m_dir, ifc.stack_cnt);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (rec_cyc_q.size() != 0) begin failures++; $display("FAIL abort_no_rec got=%0d exp=0", rec_cyc_q.size()); end
    endtask

    initial begin
        rst = 1'b1;
        ifc.fwd_valid = 1'b0;
        ifc.bwd_valid = 1'b0;
        ifc.fwd_a = '0;
        ifc.fwd_b = '0;
        test_reset();
        test_fwd_basic();
        test_bwd_basic();
        test_lifo_order();
        test_full();
        test_priority();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
